// File: rtl/mem_request_queue.sv
// In-order request FIFO in front of the memory controller, with credit-limited
// single-cycle issue pulses and registered return-response forwarding.
module mem_request_queue #(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 8,
  parameter int unsigned ADDR_W          = 16,
  parameter int unsigned DATA_W          = 16
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   req_valid,
  output logic                                   req_ready,
  input  logic                                   req_we,
  input  logic [ADDR_W-1:0]                      req_address,
  input  logic [DATA_W-1:0]                      req_data,
  output logic [ADDR_W-1:0]                      wr_address,
  output logic                                   wr_en,
  output logic [DATA_W-1:0]                      wr_data,
  output logic [ADDR_W-1:0]                      rd_address,
  output logic                                   rd_en,
  input  logic [ADDR_W-1:0]                      wr_ret_address,
  input  logic                                   wr_ret_ack,
  input  logic [ADDR_W-1:0]                      rd_ret_address,
  input  logic [DATA_W-1:0]                      rd_ret_data,
  input  logic                                   rd_ret_ack,
  output logic                                   wr_resp_valid,
  output logic [ADDR_W-1:0]                      wr_resp_address,
  output logic                                   rd_resp_valid,
  output logic [ADDR_W-1:0]                      rd_resp_address,
  output logic [DATA_W-1:0]                      rd_resp_data,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding,
  output logic                                   idle,
  output logic                                   err_underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [OW-1:0] MAX_OUT  = OW'(MAX_OUTSTANDING);

  logic              mem_we   [DEPTH];
  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] fifo_count;

  logic          push;
  logic          issue;
  logic [OW:0]   out_base;
  logic [1:0]    ack_cnt;
  logic [OW-1:0] out_next;
  logic          underflow;

  always_comb begin
    req_ready = (fifo_count != FULL_CNT);
    idle      = (fifo_count == '0) && (outstanding == '0);
    push      = req_valid && req_ready;
    issue     = (fifo_count != '0) && (outstanding < MAX_OUT);
  end

  // Acks are applied against the count including this cycle's issue; any ack
  // that would go below zero is dropped and flagged instead.
  always_comb begin
    out_base  = {1'b0, outstanding} + (OW+1)'(issue);
    ack_cnt   = {1'b0, rd_ret_ack} + {1'b0, wr_ret_ack};
    out_next  = '0;
    underflow = 1'b0;
    if ((OW+1)'(ack_cnt) > out_base) begin
      underflow = 1'b1;
    end else begin
      out_next = OW'(out_base - (OW+1)'(ack_cnt));
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_we[wr_ptr]   <= req_we;
      mem_addr[wr_ptr] <= req_address;
      mem_data[wr_ptr] <= req_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      fifo_count      <= '0;
      outstanding     <= '0;
      err_underflow   <= 1'b0;
      wr_en           <= 1'b0;
      rd_en           <= 1'b0;
      wr_address      <= '0;
      wr_data         <= '0;
      rd_address      <= '0;
      wr_resp_valid   <= 1'b0;
      wr_resp_address <= '0;
      rd_resp_valid   <= 1'b0;
      rd_resp_address <= '0;
      rd_resp_data    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (issue) rd_ptr <= rd_ptr + 1'b1;
      case ({push, issue})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase

      outstanding <= out_next;
      if (underflow) err_underflow <= 1'b1;

      wr_en <= 1'b0;
      rd_en <= 1'b0;
      if (issue) begin
        if (mem_we[rd_ptr]) begin
          wr_en      <= 1'b1;
          wr_address <= mem_addr[rd_ptr];
          wr_data    <= mem_data[rd_ptr];
        end else begin
          rd_en      <= 1'b1;
          rd_address <= mem_addr[rd_ptr];
        end
      end

      wr_resp_valid <= wr_ret_ack;
      rd_resp_valid <= rd_ret_ack;
      if (wr_ret_ack) wr_resp_address <= wr_ret_address;
      if (rd_ret_ack) begin
        rd_resp_address <= rd_ret_address;
        rd_resp_data    <= rd_ret_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_request_queue.sv
// Directed bench for mem_request_queue: reset, single read, ordering, full,
// credit limit and underflow after a mid-operation reset.
module tb_mem_request_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [15:0] req_address = '0;
  logic [15:0] req_data = '0;
  logic [15:0] wr_address;
  logic        wr_en;
  logic [15:0] wr_data;
  logic [15:0] rd_address;
  logic        rd_en;
  logic [15:0] wr_ret_address = '0;
  logic        wr_ret_ack = 1'b0;
  logic [15:0] rd_ret_address = '0;
  logic [15:0] rd_ret_data = '0;
  logic        rd_ret_ack = 1'b0;
  logic        wr_resp_valid;
  logic [15:0] wr_resp_address;
  logic        rd_resp_valid;
  logic [15:0] rd_resp_address;
  logic [15:0] rd_resp_data;
  logic [3:0]  outstanding;
  logic        idle;
  logic        err_underflow;

  int total = 0;
  int bad   = 0;

  mem_request_queue #(
    .DEPTH(4), .MAX_OUTSTANDING(8), .ADDR_W(16), .DATA_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_address(req_address), .req_data(req_data),
    .wr_address(wr_address), .wr_en(wr_en), .wr_data(wr_data),
    .rd_address(rd_address), .rd_en(rd_en),
    .wr_ret_address(wr_ret_address), .wr_ret_ack(wr_ret_ack),
    .rd_ret_address(rd_ret_address), .rd_ret_data(rd_ret_data), .rd_ret_ack(rd_ret_ack),
    .wr_resp_valid(wr_resp_valid), .wr_resp_address(wr_resp_address),
    .rd_resp_valid(rd_resp_valid), .rd_resp_address(rd_resp_address),
    .rd_resp_data(rd_resp_data),
    .outstanding(outstanding), .idle(idle), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int pulses;

    // Reset state
    tick(); tick();
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_idle", 32'(idle), 32'd1);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_rd_en", 32'(rd_en), 32'd0);
    chk("rst_outstanding", 32'(outstanding), 32'd0);
    chk("rst_err", 32'(err_underflow), 32'd0);
    rst_n = 1'b1;
    tick();

    // Single read: accepted, then issued one edge later as a one-cycle pulse
    req_valid = 1'b1; req_we = 1'b0; req_address = 16'h0040;
    tick();
    req_valid = 1'b0;
    chk("sr_no_bypass", 32'(rd_en), 32'd0);
    chk("sr_not_idle", 32'(idle), 32'd0);
    tick();
    chk("sr_rd_en", 32'(rd_en), 32'd1);
    chk("sr_rd_addr", 32'(rd_address), 32'h0040);
    chk("sr_out1", 32'(outstanding), 32'd1);
    tick();
    chk("sr_rd_en_drop", 32'(rd_en), 32'd0);
    rd_ret_ack = 1'b1; rd_ret_address = 16'h0040; rd_ret_data = 16'hBEEF;
    tick();
    rd_ret_ack = 1'b0;
    chk("sr_resp_valid", 32'(rd_resp_valid), 32'd1);
    chk("sr_resp_addr", 32'(rd_resp_address), 32'h0040);
    chk("sr_resp_data", 32'(rd_resp_data), 32'hBEEF);
    chk("sr_out0", 32'(outstanding), 32'd0);
    chk("sr_idle", 32'(idle), 32'd1);
    tick();
    chk("sr_resp_drop", 32'(rd_resp_valid), 32'd0);

    // Ordering and throughput: W, R, W back to back
    req_valid = 1'b1; req_we = 1'b1; req_address = 16'h0010; req_data = 16'h1111;
    tick();
    req_we = 1'b0; req_address = 16'h0020;
    tick();
    chk("ord_w0_en", 32'(wr_en), 32'd1);
    chk("ord_w0_rd", 32'(rd_en), 32'd0);
    chk("ord_w0_addr", 32'(wr_address), 32'h0010);
    chk("ord_w0_data", 32'(wr_data), 32'h1111);
    req_we = 1'b1; req_address = 16'h0030; req_data = 16'h3333;
    tick();
    req_valid = 1'b0;
    chk("ord_r_en", 32'(rd_en), 32'd1);
    chk("ord_r_wr", 32'(wr_en), 32'd0);
    chk("ord_r_addr", 32'(rd_address), 32'h0020);
    tick();
    chk("ord_w1_en", 32'(wr_en), 32'd1);
    chk("ord_w1_rd", 32'(rd_en), 32'd0);
    chk("ord_w1_addr", 32'(wr_address), 32'h0030);
    chk("ord_w1_data", 32'(wr_data), 32'h3333);
    tick();
    chk("ord_quiet", 32'({wr_en, rd_en}), 32'd0);
    chk("ord_out3", 32'(outstanding), 32'd3);
    wr_ret_ack = 1'b1; wr_ret_address = 16'h0010;
    rd_ret_ack = 1'b1; rd_ret_address = 16'h0020; rd_ret_data = 16'h2222;
    tick();
    rd_ret_ack = 1'b0; wr_ret_address = 16'h0030;
    chk("ord_both_resp", 32'({wr_resp_valid, rd_resp_valid}), 32'd3);
    chk("ord_wresp_addr", 32'(wr_resp_address), 32'h0010);
    chk("ord_out1", 32'(outstanding), 32'd1);
    tick();
    wr_ret_ack = 1'b0;
    chk("ord_wresp_addr2", 32'(wr_resp_address), 32'h0030);
    chk("ord_rresp_hold", 32'(rd_resp_address), 32'h0020);
    chk("ord_idle", 32'(idle), 32'd1);

    // Credit limit: 10 reads, only 8 may issue
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      req_valid = 1'b1; req_we = 1'b0; req_address = 16'(32'h0100 + i);
      tick();
      if (rd_en) pulses++;
    end
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (rd_en) pulses++;
    end
    chk("cl_pulses", 32'(pulses), 32'd8);
    chk("cl_last_addr", 32'(rd_address), 32'h0107);
    chk("cl_out8", 32'(outstanding), 32'd8);
    chk("cl_ready", 32'(req_ready), 32'd1);
    rd_ret_ack = 1'b1; wr_ret_ack = 1'b1;
    tick();
    rd_ret_ack = 1'b0; wr_ret_ack = 1'b0;
    chk("cl_out6", 32'(outstanding), 32'd6);
    chk("cl_noissue_ack", 32'(rd_en), 32'd0);
    tick();
    chk("cl_i8_en", 32'(rd_en), 32'd1);
    chk("cl_i8_addr", 32'(rd_address), 32'h0108);
    tick();
    chk("cl_i9_en", 32'(rd_en), 32'd1);
    chk("cl_i9_addr", 32'(rd_address), 32'h0109);
    chk("cl_i9_out", 32'(outstanding), 32'd8);
    tick();
    chk("cl_stop", 32'(rd_en), 32'd0);

    // Full: credits exhausted, fill 4 entries, hold off a 5th
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; req_we = 1'b1;
      req_address = 16'(32'h0200 + i); req_data = 16'(32'hA000 + i);
      tick();
      chk("full_ready", 32'(req_ready), (i < 3) ? 32'd1 : 32'd0);
    end
    req_address = 16'h0204; req_data = 16'hA004;
    tick(); tick();
    chk("full_held_ready", 32'(req_ready), 32'd0);
    chk("full_held_wr", 32'(wr_en), 32'd0);
    rd_ret_ack = 1'b1;
    tick();
    rd_ret_ack = 1'b0;
    chk("full_ack_out7", 32'(outstanding), 32'd7);
    chk("full_ack_ready", 32'(req_ready), 32'd0);
    tick();
    chk("full_pop_en", 32'(wr_en), 32'd1);
    chk("full_pop_addr", 32'(wr_address), 32'h0200);
    chk("full_pop_data", 32'(wr_data), 32'hA000);
    chk("full_pop_ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    chk("full_5th_in", 32'(req_ready), 32'd0);
    chk("full_5th_noissue", 32'(wr_en), 32'd0);
    wr_ret_ack = 1'b1; wr_ret_address = 16'h0000;
    tick();
    chk("drain_first", 32'(outstanding), 32'd7);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("drain_en", 32'(wr_en), 32'd1);
      chk("drain_addr", 32'(wr_address), 32'(32'h0201 + k));
      chk("drain_data", 32'(wr_data), 32'(32'hA001 + k));
    end
    repeat (7) tick();
    wr_ret_ack = 1'b0;
    chk("drain_out0", 32'(outstanding), 32'd0);
    chk("drain_idle", 32'(idle), 32'd1);
    chk("drain_no_err", 32'(err_underflow), 32'd0);

    // Underflow after a mid-operation reset
    req_valid = 1'b1; req_we = 1'b0; req_address = 16'h0300;
    tick();
    req_address = 16'h0301;
    tick();
    req_valid = 1'b0;
    tick();
    chk("uf_out2", 32'(outstanding), 32'd2);
    chk("uf_rd_en", 32'(rd_en), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("uf_rst_out", 32'(outstanding), 32'd0);
    chk("uf_rst_rd_en", 32'(rd_en), 32'd0);
    chk("uf_rst_rd_addr", 32'(rd_address), 32'd0);
    chk("uf_rst_wr_addr", 32'(wr_address), 32'd0);
    chk("uf_rst_resp", 32'(wr_resp_address), 32'd0);
    chk("uf_rst_idle", 32'(idle), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    rd_ret_ack = 1'b1; rd_ret_address = 16'h0300; rd_ret_data = 16'h1234;
    tick();
    chk("uf_resp1", 32'(rd_resp_valid), 32'd1);
    chk("uf_out_floor1", 32'(outstanding), 32'd0);
    chk("uf_err1", 32'(err_underflow), 32'd1);
    rd_ret_address = 16'h0301; rd_ret_data = 16'h5678;
    tick();
    rd_ret_ack = 1'b0;
    chk("uf_resp2", 32'(rd_resp_valid), 32'd1);
    chk("uf_resp2_data", 32'(rd_resp_data), 32'h5678);
    chk("uf_out_floor2", 32'(outstanding), 32'd0);
    tick();
    chk("uf_resp_drop", 32'(rd_resp_valid), 32'd0);
    chk("uf_err_sticky", 32'(err_underflow), 32'd1);
    chk("uf_idle", 32'(idle), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
